led_pattern_sched: RTL



---
 rtl/led_pattern_sched_pkg.sv | 22 ++
 rtl/led_tick_gen.sv | 50 +++++
 rtl/led_pattern_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/led_pattern_sched_pkg.sv
// Shared encodings for the LED pattern scheduler: pattern modes, FSM states
// and the bounce direction.
package led_pattern_sched_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Shared time base: a prescaler producing a tick every TICK_MAX+1 enabled
// cycles, and a step counter producing a step every STEP_TICKS ticks.
module led_tick_gen #(
    parameter int unsigned TICK_MAX   = 49_999,
    parameter int unsigned STEP_TICKS = 250,
    parameter int unsigned TICK_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic step
);

    localparam int unsigned STEP_W = 16;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

    always_comb begin
        tick       = en && (tick_cnt_q == TICK_LAST);
        step       = tick && (step_cnt_q == STEP_LAST);
        tick_cnt_d = tick_cnt_q;
        step_cnt_d = step_cnt_q;
        // clr overrides en so a clear still takes effect while frozen
        if (clr) begin
            tick_cnt_d = '0;
            step_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            if (tick) begin
                step_cnt_d = step ? '0 : step_cnt_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: sequences the LED bank through OFF/BLINK/CHASE/BOUNCE
// on a shared time base, with a valid/ready port for runtime mode changes.
module led_pattern_sched
    import led_pattern_sched_pkg::*;
#(
    parameter int unsigned NUM_LED    = 5,
    parameter int unsigned TICK_MAX   = 49_999,
    parameter int unsigned STEP_TICKS = 250,
    parameter int unsigned TICK_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode_req_valid,
    input  logic [1:0]         mode_req,
    output logic               mode_req_ready,
    output logic [1:0]         mode,
    output logic               step_pulse,
    output logic [NUM_LED-1:0] led
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    mode_e              cap_q, cap_d;
    dir_e               dir_q, dir_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               step_pulse_q, step_pulse_d;
    logic               clr;
    logic               tick;
    logic               step;

    led_tick_gen #(
        .TICK_MAX   (TICK_MAX),
        .STEP_TICKS (STEP_TICKS),
        .TICK_W     (TICK_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick),
        .step (step)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cap_d        = cap_q;
        dir_d        = dir_q;
        led_d        = led_q;
        step_pulse_d = 1'b0;
        clr          = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A request takes priority over a step due in the same cycle
                if (mode_req_valid) begin
                    state_d = ST_SWITCH;
                    cap_d   = mode_e'(mode_req);
                    led_d   = '0;
                    clr     = 1'b1;
                end else if (step && tick) begin
                    step_pulse_d = 1'b1;
                    case (mode_q)
                        MODE_OFF:   led_d = '0;
                        MODE_BLINK: led_d = ~led_q;
                        MODE_CHASE: led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
                        MODE_BOUNCE: begin
                            // Flip direction as we land on an end LED so it is lit one step only
                            if (dir_q == DIR_UP) begin
                                led_d = led_q << 1;
                                if (led_q[NUM_LED-2]) dir_d = DIR_DOWN;
                            end else begin
                                led_d = led_q >> 1;
                                if (led_q[1]) dir_d = DIR_UP;
                            end
                        end
                    endcase
                end
            end
            ST_SWITCH: begin
                clr     = 1'b1;
                state_d = ST_RUN;
                mode_d  = cap_q;
                dir_d   = DIR_UP;
                case (cap_q)
                    MODE_OFF:   led_d = '0;
                    MODE_BLINK: led_d = '1;
                    default:    led_d = NUM_LED'(1);
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            mode_q       <= MODE_OFF;
            cap_q        <= MODE_OFF;
            dir_q        <= DIR_UP;
            led_q        <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cap_q        <= cap_d;
            dir_q        <= dir_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign mode_req_ready = (state_q == ST_RUN);
    assign mode           = mode_q;
    assign step_pulse     = step_pulse_q;
    assign led            = led_q;

endmodule
